// File: rtl/wb_counter_arbiter.sv
// ---------------------------------------------------------------------------
// wb_counter_arbiter
//   Two-master, one-slave Wishbone arbiter in front of the user-project
//   counter. Round-robin between masters on a tie, grant held for the whole
//   cyc window (bursts allowed), and a per-grant ack watchdog that raises a
//   one-cycle err to the granted master when the slave never answers.
//
// Parameters
//   TIMEOUT   : wait cycles allowed for s_ack_i per strobe, 1..255
//
// Ports
//   wb_clk_i, wb_rst_i            : clock, async active-high reset
//   mN_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i : master N request (N = 0,1)
//   mN_dat_o/ack_o/err_o          : master N response
//   s_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o  : forwarded request to slave
//   s_dat_i, s_ack_i              : slave response
// ---------------------------------------------------------------------------
module wb_counter_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // wait_cnt value on the last strobe cycle still allowed to see an ack
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    logic req0, req1;
    logic cur_cyc, cur_stb;
    logic timeout;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // Bus signals of whichever master currently owns the slave
    always_comb begin
        cur_cyc = 1'b0;
        cur_stb = 1'b0;
        case (state_q)
            GNT0: begin
                cur_cyc = m0_cyc_i;
                cur_stb = m0_stb_i;
            end
            GNT1: begin
                cur_cyc = m1_cyc_i;
                cur_stb = m1_stb_i;
            end
            default: ;
        endcase
    end

    // ack in the same cycle beats the watchdog
    assign timeout = (state_q != IDLE) & cur_stb & ~s_ack_i & (wait_cnt_q == TO_LAST);

    // Combinational forwarding; everything reads 0 while IDLE (and so during reset)
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = 4'h0;
        s_adr_o  = 32'h0;
        s_dat_o  = 32'h0;
        m0_dat_o = 32'h0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = 32'h0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i & m0_stb_i;
                m0_err_o = timeout;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i & m1_stb_i;
                m1_err_o = timeout;
            end
            default: ;
        endcase
    end

    // Arbitration and watchdog next-state
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                wait_cnt_d = 8'h00;
                if (req0 && req1)
                    state_d = last_q ? GNT0 : GNT1;
                else if (req0)
                    state_d = GNT0;
                else if (req1)
                    state_d = GNT1;
            end
            GNT0, GNT1: begin
                if (s_ack_i || !cur_stb)
                    wait_cnt_d = 8'h00;
                else if (wait_cnt_q != 8'hFF)
                    wait_cnt_d = wait_cnt_q + 8'h01;
                // Release on cyc drop or timeout; always passes through IDLE
                if (!cur_cyc || timeout) begin
                    state_d = IDLE;
                    last_d  = (state_q == GNT1);
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = 8'h00;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;   // master 0 wins the first tie
            wait_cnt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_counter_arbiter.sv
module tb_wb_counter_arbiter;

    localparam int TO = 4;
    localparam logic [31:0] A0 = 32'h3000_0000, D0 = 32'h0000_AB60;
    localparam logic [31:0] A1 = 32'h3000_0004, D1 = 32'h0000_1111;

    logic        clk = 1'b0, rst = 1'b1;
    logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    wb_counter_arbiter #(.TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: -1 none, else index of master holding the slave
    int m_owner, m_last, m_waited;

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_waited = 0;
    endtask

    // Compare all outputs against the model, then advance the model one edge.
    task automatic step();
        logic        c[2], s[2], w[2];
        logic [3:0]  sl[2];
        logic [31:0] ad[2], dt[2];
        logic        ecyc, estb, ewe, err;
        logic [3:0]  esel;
        logic [31:0] eadr, edat;
        logic [31:0] ed[2];
        logic        ea[2], ee[2];
        #1;
        c  = '{m0_cyc_i, m1_cyc_i}; s  = '{m0_stb_i, m1_stb_i}; w = '{m0_we_i, m1_we_i};
        sl = '{m0_sel_i, m1_sel_i}; ad = '{m0_adr_i, m1_adr_i}; dt = '{m0_dat_i, m1_dat_i};
        ecyc = 0; estb = 0; ewe = 0; esel = 0; eadr = 0; edat = 0; err = 0;
        ed = '{32'h0, 32'h0}; ea = '{1'b0, 1'b0}; ee = '{1'b0, 1'b0};
        if (m_owner >= 0) begin
            ecyc = c[m_owner]; estb = s[m_owner]; ewe = w[m_owner];
            esel = sl[m_owner]; eadr = ad[m_owner]; edat = dt[m_owner];
            ed[m_owner] = s_dat_i;
            ea[m_owner] = s_ack_i & s[m_owner];
            err = s[m_owner] & ~s_ack_i & (m_waited == TO - 1);
            ee[m_owner] = err;
        end
        chk("s_cyc", 32'(s_cyc_o), 32'(ecyc));
        chk("s_stb", 32'(s_stb_o), 32'(estb));
        chk("s_we",  32'(s_we_o),  32'(ewe));
        chk("s_sel", 32'(s_sel_o), 32'(esel));
        chk("s_adr", s_adr_o, eadr);
        chk("s_dat", s_dat_o, edat);
        chk("m0_dat", m0_dat_o, ed[0]);
        chk("m1_dat", m1_dat_o, ed[1]);
        chk("m0_ack", 32'(m0_ack_o), 32'(ea[0]));
        chk("m1_ack", 32'(m1_ack_o), 32'(ea[1]));
        chk("m0_err", 32'(m0_err_o), 32'(ee[0]));
        chk("m1_err", 32'(m1_err_o), 32'(ee[1]));
        chk("ack_err_excl", 32'((m0_ack_o & m0_err_o) | (m1_ack_o & m1_err_o)), 32'h0);
        if (rst) model_reset();
        else if (m_owner < 0) begin
            m_waited = 0;
            if (c[0] & s[0] & c[1] & s[1]) m_owner = (m_last == 1) ? 0 : 1;
            else if (c[0] & s[0])          m_owner = 0;
            else if (c[1] & s[1])          m_owner = 1;
        end else if (!c[m_owner] || err) begin
            m_last = m_owner; m_owner = -1; m_waited = 0;
        end else if (s_ack_i || !s[m_owner]) m_waited = 0;
        else if (m_waited < 255) m_waited++;
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 1; m0_sel_i = 4'hF; m0_adr_i = A0; m0_dat_i = D0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'h3; m1_adr_i = A1; m1_dat_i = D1;
        s_ack_i = 0; s_dat_i = 32'hC0DE_0000;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs(); model_reset();
        tick(); step(); tick();
        rst = 0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic c0, s0, c1, s1, ack;
        int   g;               // expected owner: 0 none, 1 m0, 2 m1
        logic a0, a1, e0, e1;
    } vec_t;
    vec_t tbl[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0,0,0,0,0, 0, 0,0,0,0};
        tbl[1]  = '{1,1,0,0,0, 0, 0,0,0,0};
        tbl[2]  = '{1,1,0,0,0, 1, 0,0,0,0};
        tbl[3]  = '{1,1,0,0,1, 1, 1,0,0,0};
        tbl[4]  = '{0,0,0,0,0, 1, 0,0,0,0};
        tbl[5]  = '{1,1,1,1,0, 0, 0,0,0,0};
        tbl[6]  = '{1,1,1,1,1, 2, 0,1,0,0};
        tbl[7]  = '{1,1,0,0,0, 2, 0,0,0,0};
        tbl[8]  = '{1,1,0,0,0, 0, 0,0,0,0};
        tbl[9]  = '{1,1,0,0,0, 1, 0,0,0,0};
        tbl[10] = '{1,1,0,0,0, 1, 0,0,0,0};
        tbl[11] = '{1,1,0,0,0, 1, 0,0,0,0};
        tbl[12] = '{1,1,0,0,0, 1, 0,0,1,0};
        tbl[13] = '{1,1,0,0,0, 0, 0,0,0,0};
        tbl[14] = '{0,0,0,0,1, 1, 0,0,0,0};
        tbl[15] = '{0,0,0,0,1, 0, 0,0,0,0};

        idle_inputs();
        @(negedge clk); #1;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            logic ec;
            m0_cyc_i = tbl[i].c0; m0_stb_i = tbl[i].s0;
            m1_cyc_i = tbl[i].c1; m1_stb_i = tbl[i].s1;
            s_ack_i  = tbl[i].ack; s_dat_i = 32'h5A00_0000 + 32'(i);
            #1;
            ec = (tbl[i].g == 1) ? tbl[i].c0 : (tbl[i].g == 2) ? tbl[i].c1 : 1'b0;
            chk($sformatf("tbl%0d s_cyc", i), 32'(s_cyc_o), 32'(ec));
            chk($sformatf("tbl%0d s_adr", i), s_adr_o,
                (tbl[i].g == 1) ? A0 : (tbl[i].g == 2) ? A1 : 32'h0);
            chk($sformatf("tbl%0d s_dat", i), s_dat_o,
                (tbl[i].g == 1) ? D0 : (tbl[i].g == 2) ? D1 : 32'h0);
            chk($sformatf("tbl%0d m0_dat", i), m0_dat_o, (tbl[i].g == 1) ? s_dat_i : 32'h0);
            chk($sformatf("tbl%0d m1_dat", i), m1_dat_o, (tbl[i].g == 2) ? s_dat_i : 32'h0);
            chk($sformatf("tbl%0d m0_ack", i), 32'(m0_ack_o), 32'(tbl[i].a0));
            chk($sformatf("tbl%0d m1_ack", i), 32'(m1_ack_o), 32'(tbl[i].a1));
            chk($sformatf("tbl%0d m0_err", i), 32'(m0_err_o), 32'(tbl[i].e0));
            chk($sformatf("tbl%0d m1_err", i), 32'(m1_err_o), 32'(tbl[i].e1));
            tick();
        end

        // ---- burst on m1 with m0 pending; m0 granted only after m1 lets go
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1;
        step(); tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int k = 1; k <= 4; k++) begin
            s_ack_i = 1; s_dat_i = 32'(k);
            #1;
            chk("burst m1_dat", m1_dat_o, 32'(k));
            chk("burst m1_ack", 32'(m1_ack_o), 32'h1);
            chk("burst m0_ack", 32'(m0_ack_o), 32'h0);
            step(); tick();
        end
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step(); tick();
        #1 chk("burst gap s_cyc", 32'(s_cyc_o), 32'h0);
        step(); tick();
        #1 chk("burst m0 grant adr", s_adr_o, A0);
        step(); tick();

        // ---- ack/timeout collision, then a real timeout handing over to m1
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        step(); tick();
        m1_cyc_i = 1; m1_stb_i = 1;
        for (int k = 0; k < 3; k++) begin step(); tick(); end
        s_ack_i = 1;
        #1;
        chk("collide m0_ack", 32'(m0_ack_o), 32'h1);
        chk("collide m0_err", 32'(m0_err_o), 32'h0);
        step(); tick();
        s_ack_i = 0;
        for (int k = 0; k < 3; k++) begin step(); tick(); end
        #1 chk("timeout m0_err", 32'(m0_err_o), 32'h1);
        step(); tick();
        m0_cyc_i = 0; m0_stb_i = 0;
        #1 chk("timeout then idle s_cyc", 32'(s_cyc_o), 32'h0);
        step(); tick();
        #1 chk("timeout m1 granted", s_adr_o, A1);
        step(); tick();

        // ---- async reset in the middle of an m1 burst
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1;
        step(); tick();
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
        #1 chk("pre-reset m1_ack", 32'(m1_ack_o), 32'h1);
        #1 rst = 1;
        #1;
        chk("async rst s_cyc", 32'(s_cyc_o), 32'h0);
        chk("async rst m1_ack", 32'(m1_ack_o), 32'h0);
        chk("async rst m1_dat", m1_dat_o, 32'h0);
        chk("async rst s_adr", s_adr_o, 32'h0);
        model_reset();
        tick(); step(); tick();
        rst = 0; s_ack_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step(); tick();
        #1 chk("post-reset tie to m0", s_adr_o, A0);
        step(); tick();

        // ---- randomized traffic against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if (m0_cyc_i) m0_cyc_i = ($urandom_range(5) != 0);
            else          m0_cyc_i = ($urandom_range(2) == 0);
            if (m1_cyc_i) m1_cyc_i = ($urandom_range(5) != 0);
            else          m1_cyc_i = ($urandom_range(2) == 0);
            m0_stb_i = ($urandom_range(3) != 0);
            m1_stb_i = ($urandom_range(3) != 0);
            m0_we_i  = 1'($urandom); m1_we_i = 1'($urandom);
            m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
            m0_adr_i = $urandom; m1_adr_i = $urandom;
            m0_dat_i = $urandom; m1_dat_i = $urandom;
            s_dat_i  = $urandom;
            s_ack_i  = ($urandom_range(3) == 0);
            step(); tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_counter_arbiter.md
WB_COUNTER_ARBITER -- requirements
Module: wb_counter_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum wait cycles for slave ack, legal range 1..255.
REQ-002 SHALL have port wb_clk_i, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have, for N in {0,1}, the following master ports: mN_cyc_i/mN_stb_i/mN_we_i, input, 1 bit each; mN_sel_i, input, 4 bits; mN_adr_i and mN_dat_i, input, 32 bits each.
REQ-005 SHALL have, for N in {0,1}, the following master ports: mN_dat_o, output, 32 bits; mN_ack_o and mN_err_o, output, 1 bit each.
REQ-006 SHALL have slave ports s_cyc_o/s_stb_o/s_we_o, output, 1 bit each; s_sel_o, output, 4 bits; s_adr_o and s_dat_o, output, 32 bits each.
REQ-007 SHALL have slave ports s_dat_i, input, 32 bits; s_ack_i, input, 1 bit. The slave is the user-project counter.

Function
REQ-008 SHALL implement FSM states IDLE, GNT0 and GNT1, plus a 1-bit register last and an 8-bit register wait_cnt.
REQ-009 SHALL define reqN = mN_cyc_i & mN_stb_i.
REQ-010 In IDLE, if only reqN is high, the FSM SHALL go to GNTN next cycle.
REQ-011 In IDLE, if req0 and req1 are both high, the FSM SHALL go to GNT0 when last=1 and to GNT1 when last=0 (round-robin).
REQ-012 Grant latency SHALL be exactly one cycle, request to s_cyc_o high; no slave signal is asserted in IDLE.
REQ-013 In GNTN, s_cyc_o SHALL equal mN_cyc_i and s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o SHALL equal the mN_* inputs, combinationally.
REQ-014 In IDLE all slave outputs SHALL be 0.
REQ-015 In GNTN: mN_ack_o = s_ack_i & mN_stb_i; mN_dat_o = s_dat_i.
REQ-016 The non-granted master SHALL see ack=0, err=0 and dat_o=0.
REQ-017 Grant SHALL be held while mN_cyc_i stays high, so block/burst cycles with several stb/ack pairs are allowed and the other master's request is ignored.
REQ-018 When mN_cyc_i falls in GNTN, the next state SHALL be IDLE and last SHALL be set to N; there is always one idle cycle between grants.
REQ-019 wait_cnt SHALL clear in IDLE, on any cycle with s_ack_i=1, and on any cycle with mN_stb_i=0.
REQ-020 Otherwise, in GNTN, wait_cnt SHALL increment by 1 and saturate at 255.
REQ-021 When wait_cnt == TIMEOUT-1 and s_ack_i=0 with stb high, mN_err_o SHALL pulse high for exactly that cycle, with mN_ack_o=0.
REQ-022 On that timeout, the next state SHALL be IDLE, last SHALL be set to N, and the master is expected to drop cyc.
REQ-023 If mN_cyc_i is still high in IDLE after a timeout, it is treated as a new request.
REQ-024 If s_ack_i and the timeout condition fall in the same cycle, ack SHALL win: no err, counter clears.
REQ-025 s_ack_i arriving while in IDLE SHALL be ignored and never forwarded.
REQ-026 mN_err_o and mN_ack_o SHALL never both be high in the same cycle.

Reset
REQ-027 Asserting wb_rst_i SHALL immediately force: state IDLE, last=1 (master 0 wins the first tie), wait_cnt=0.
REQ-028 During reset all outputs SHALL be 0.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer with no ack or err generated.
REQ-030 After deassertion, the first arbitration SHALL occur on the first rising edge with wb_rst_i low.

Verification
REQ-031 Single master: m0 write adr 0x30000000, dat 0x0000AB60, slave acks on 2nd granted cycle -> s_cyc_o high 1 cycle after req0, m0_ack_o 1 cycle, counter receives 0x0000AB60, m1 outputs stay 0.
REQ-032 Tie after reset: req0 and req1 rise together -> GNT0 first; after m0 drops cyc, 1 IDLE cycle, then GNT1; next tie goes to GNT0.
REQ-033 Burst: m1 holds cyc for 4 reads with req0 pending, slave returns 0x1,0x2,0x3,0x4 -> m1_dat_o shows each with ack; m0 granted only after m1 cyc falls.
REQ-034 Timeout: TIMEOUT=4, slave never acks m0 -> m0_err_o high on 4th granted stb cycle, s_cyc_o low next cycle, pending m1 granted next.
REQ-035 Ack/timeout collision: TIMEOUT=4, s_ack_i on 4th cycle -> m0_ack_o=1, m0_err_o=0.
REQ-036 Async reset mid-burst: wb_rst_i pulsed between clock edges during GNT1 -> all outputs 0 before next edge, no ack/err; after release, req0 and req1 tie -> GNT0.
